bus_responder: RTL



---
 rtl/processor_pkg.sv | 19 +
 rtl/key_fifo.sv | 79 +++++++
 rtl/bus_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared constants for the processor memory bus and its I/O page.
// Holds the I/O address map, KEY_STAT bit positions and bus widths used by
// bus_responder and key_fifo.
package processor_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 8;
   localparam int NUM_DIGITS = 8;

   localparam logic [7:0]        IO_PAGE    = 8'hC0;
   localparam logic [ADDR_W-1:0] A_KEY_STAT = 16'hC000;
   localparam logic [ADDR_W-1:0] A_KEY_DATA = 16'hC001;
   localparam logic [ADDR_W-1:0] A_DIGIT0   = 16'hC002;

   // Bit positions inside the KEY_STAT byte.
   localparam int KS_NEMPTY = 0;
   localparam int KS_OVF    = 1;

endpackage

// File: rtl/key_fifo.sv
// Keypad scan-code FIFO.
// Ports:
//   clock_25, reset : clock and asynchronous active-high reset
//   push, din       : enqueue request and scan code
//   pop             : dequeue request (ignored when empty)
//   dout            : head entry, 0 when empty
//   empty, full     : occupancy flags
//   ovf_set         : one-cycle pulse, a push was dropped on this edge
// A push into a full FIFO is accepted when a pop frees a slot on the same
// edge; only a push that finds no room raises ovf_set.
module key_fifo
   import processor_pkg::*;
#(
   parameter int KEY_DEPTH = 4
) (
   input  logic              clock_25,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic              ovf_set
);

   localparam int PW = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(KEY_DEPTH);

   logic [DATA_W-1:0] mem_q [KEY_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              pop_ok;
   logic              push_ok;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CNT_MAX);
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      ovf_set  = push && !push_ok;
      dout     = empty ? '0 : mem_q[rd_ptr_q];

      // Pointers are power-of-two wide, so plain increment wraps.
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      count_d  = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clock_25) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/bus_responder.sv
// Target side of the 8-bit processor memory bus.
// Ports:
//   clock_25, reset    : clock and asynchronous active-high reset
//   addr, wdata, wr    : processor request; wr=1 writes on the rising edge
//   rdata              : read data, registered on the falling edge
//   key_code, key_strobe : keypad scan code and its one-cycle push pulse
//   seg, dig           : 7-segment lines (1 = lit) and active-low digit select
// Bus protocol: there is no handshake. Every cycle is a complete transfer;
// rdata is captured on the falling edge from that cycle's addr and the
// processor samples it on the following rising edge (zero wait states).
// Writes commit on the rising edge when wr=1.
// Memory map: $C000-$C0FF is the I/O page; everything else is RAM of
// 2^RAM_AW bytes, mirrored.
module bus_responder
   import processor_pkg::*;
#(
   parameter int RAM_AW    = 12,
   parameter int KEY_DEPTH = 4,
   parameter int SCAN_DIV  = 12500
) (
   input  logic              clock_25,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wr,
   output logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] key_code,
   input  logic              key_strobe,
   output logic [7:0]        seg,
   output logic [7:0]        dig
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
   localparam logic [7:0]        DIG_BASE  = A_DIGIT0[7:0];

   // ---------------------------------------------------------------- state
   logic [DATA_W-1:0] ram_q [2**RAM_AW];
   logic [DATA_W-1:0] digit_q [NUM_DIGITS];
   logic [DATA_W-1:0] digit_d [NUM_DIGITS];
   logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] popped_q, popped_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        seg_q, seg_d;
   logic [7:0]        dig_q, dig_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // --------------------------------------------------------------- decode
   logic              io_sel;
   logic [7:0]        dig_off;
   logic              dig_sel;
   logic              ram_we;
   logic              key_pop;
   logic              key_held;
   logic              ovf_clr;
   logic [DATA_W-1:0] key_stat;

   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_ovf_set;

   always_comb begin
      io_sel   = (addr[15:8] == IO_PAGE);
      // Addresses below DIGIT0 wrap to large offsets and fall out of range.
      dig_off  = addr[7:0] - DIG_BASE;
      dig_sel  = io_sel && (dig_off < 8'(NUM_DIGITS));
      ram_we   = wr && !io_sel;
      ovf_clr  = wr && (addr == A_KEY_STAT);
      key_held = (prev_addr_q == A_KEY_DATA);
      // A held KEY_DATA address pops only on its first cycle.
      key_pop  = !wr && (addr == A_KEY_DATA) && !key_held;

      key_stat           = '0;
      key_stat[KS_NEMPTY] = !fifo_empty;
      key_stat[KS_OVF]    = ovf_q;
   end

   key_fifo #(
      .KEY_DEPTH (KEY_DEPTH)
   ) u_key_fifo (
      .clock_25 (clock_25),
      .reset    (reset),
      .push     (key_strobe),
      .din      (key_code),
      .pop      (key_pop),
      .dout     (fifo_dout),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .ovf_set  (fifo_ovf_set)
   );

   // ---------------------------------------------------- next-state logic
   always_comb begin
      prev_addr_d = addr;
      // Set beats clear when both happen on the same edge.
      ovf_d       = fifo_ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
      // The byte consumed by a pop keeps being returned while the processor
      // holds $C001, so a multi-cycle read sees one stable value.
      popped_d    = key_pop ? fifo_dout : popped_q;

      digit_d = digit_q;
      if (wr && dig_sel) begin
         digit_d[dig_off[2:0]] = wdata;
      end

      scan_cnt_d = scan_cnt_q + SCAN_ONE;
      idx_d      = idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 3'd1;
      end
      // Both display outputs are built from next-state values so seg always
      // matches the digit dig selects, including a write on the same edge.
      dig_d = ~(8'b1 << idx_d);
      seg_d = digit_d[idx_d];
   end

   // Read mux, sampled on the falling edge.
   always_comb begin
      rdata_d = 8'hFF;
      if (!io_sel) begin
         rdata_d = ram_q[addr[RAM_AW-1:0]];
      end else if (addr == A_KEY_STAT) begin
         rdata_d = key_stat;
      end else if (addr == A_KEY_DATA) begin
         rdata_d = key_held ? popped_q : fifo_dout;
      end else if (dig_sel) begin
         rdata_d = digit_q[dig_off[2:0]];
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clock_25 or posedge reset) begin
      if (reset) begin
         prev_addr_q <= '0;
         ovf_q       <= 1'b0;
         popped_q    <= '0;
         scan_cnt_q  <= '0;
         idx_q       <= '0;
         seg_q       <= '0;
         dig_q       <= 8'hFE;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_q[i] <= '0;
         end
      end else begin
         prev_addr_q <= prev_addr_d;
         ovf_q       <= ovf_d;
         popped_q    <= popped_d;
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         seg_q       <= seg_d;
         dig_q       <= dig_d;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_q[i] <= digit_d[i];
         end
      end
   end

   always_ff @(negedge clock_25 or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clock_25) begin
      if (ram_we) begin
         ram_q[addr[RAM_AW-1:0]] <= wdata;
      end
   end

   assign rdata = rdata_q;
   assign seg   = seg_q;
   assign dig   = dig_q;

endmodule
